output_error_unit: RTL
======================

# output_error_unit

Loss/error stage at the tail of the CNN datapath: it consumes the `FULLY_CONNECTED` forward outputs for one sample plus the sample's class label. It produces the per-class output error (`fc_output − one_hot(label)`) as a valid/ready stream feeding the backprop path. It also keeps per-sample correctness and per-batch loss and accuracy, so training is sequenced in hardware rather than from the bench.

## Interface
Parameters:
- `OUTPUT_SIZE`, 10: classes per sample (FC output count).
- `DATA_WIDTH`, 16: signed fixed-point width of FC outputs and errors.
- `FRAC_BITS`, 8: fractional bits (Q8.8), so 1.0 = 16'h0100.
- `BATCH_SIZE`, 32: samples per batch.
- `LOSS_WIDTH`, 32: loss accumulator width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `start` in 1: one-cycle pulse that begins a sample; `label` is sampled on it.
- `label` in `$clog2(OUTPUT_SIZE)`: true class index.
- `fc_data` in `DATA_WIDTH`: FC output value, class order 0..`OUTPUT_SIZE`−1.
- `fc_valid` in 1: `fc_data` valid this cycle; no backpressure.
- `err_data` out `DATA_WIDTH`: error for class `err_index`.
- `err_index` out `$clog2(OUTPUT_SIZE)`: class of the current error beat.
- `err_valid` out 1: error beat valid.
- `err_ready` in 1: consumer accepts the beat when high with `err_valid`.
- `busy` out 1: high from the accepted `start` until `sample_done`.
- `sample_done` out 1: one-cycle pulse at the end of a sample.
- `correct` out 1: argmax equals label; valid with `sample_done`, held until the next `sample_done`.
- `batch_done` out 1: one-cycle pulse, coincident with the `BATCH_SIZE`-th `sample_done`.
- `batch_loss` out `LOSS_WIDTH`: summed |error| of the last completed batch.
- `batch_correct` out `$clog2(BATCH_SIZE+1)`: correct count of the last completed batch.

## Operation
State machine:
- IDLE → COLLECT on `start`; `label` is registered.
- COLLECT: each `fc_valid` writes `fc_data` to `buf[cnt]` and increments `cnt`.
  - Running argmax uses strict `>`, so on a tie the lowest index wins. The first value initialises it.
  - COLLECT → EMIT after the `OUTPUT_SIZE`-th value.
- EMIT: beat `i` carries `err_data = sat(buf[i] − (i==label ? 1<<FRAC_BITS : 0))`.
  - Subtraction is done at `DATA_WIDTH`+1 bits, then saturated to [−32768, 32767].
  - Sample loss accumulates `|err_data|` on each accepted beat; |−32768| counts as 32767.
  - EMIT → DONE when the last beat is accepted.
- DONE (one cycle): pulse `sample_done` and update `correct`.
  - Add the sample loss to the batch accumulator, saturating at 2^`LOSS_WIDTH`−1.
  - Increment the correct accumulator if `correct` and increment the sample counter.
  - If the counter reaches `BATCH_SIZE`: copy the accumulators to `batch_loss`/`batch_correct`, clear the accumulators and counter, and pulse `batch_done`.
  - DONE → IDLE.

Boundary rules:
- `start` while `busy` is ignored.
- `fc_valid` outside COLLECT is ignored.
- `label` ≥ `OUTPUT_SIZE`: no class is subtracted and `correct`=0.
- `start` and a final `fc_valid` in the same cycle in IDLE: the `fc_valid` is ignored.
- `reset` mid-sample abandons the sample. The batch counter, accumulators and outputs all return to 0.

## Timing
- Reset values: every output is 0; the state is IDLE.
- `start` at cycle S: `busy`=1 from S+1, and COLLECT accepts `fc_valid` from S+1.
- Last `fc_valid` at cycle N: `err_valid`=1 with `err_index`=0 at N+1.
- With `err_ready` held high, beats occupy N+1..N+`OUTPUT_SIZE`, and `sample_done` pulses at N+`OUTPUT_SIZE`+1.
- `busy` falls in the cycle after `sample_done`.
- `err_data`/`err_index` are stable while `err_valid` && !`err_ready`. `err_valid` never drops before acceptance.
- `batch_loss`/`batch_correct` update in the same cycle as `batch_done`.

## Structure
- Shared package `cnn_pkg`: Q8.8 constants (`FIXED_ONE`=16'h0100, `FRAC_BITS`), the saturating add/sub and abs functions, and the state enum.
- One sub-module, `argmax_tracker`: streaming max value/index, reset per sample, with the strict-greater tie rule.
- The value buffer is a register array of `OUTPUT_SIZE` × `DATA_WIDTH`.

## Test plan
1. Basic sample: `label`=3; fc values 0..9 = 16'h0010 each except [3]=16'h0200, `err_ready`=1.
   - errors all 16'h0010 except [3]=16'h0100; `correct`=1; sample loss 9×16+256=400.
   - `sample_done` 11 cycles after the last input.
2. Backpressure: as test 1, with `err_ready` toggling 1,0,0,1.
   - No beat is lost or duplicated; data is held while stalled; the same 10 errors appear in order.
3. Saturation and ties:
   - fc[0]=16'h8000 with `label`=0 → err[0]=16'h8000; the abs contribution is 32767.
   - All fc equal with `label`=4 → argmax=0, `correct`=0.
4. Batch wrap: 32 samples, the first 20 matching test 1 and the rest with label ≠ argmax.
   - `batch_done` coincides with the 32nd `sample_done`; `batch_correct`=20.
   - The accumulators then restart at 0.
5. Reset mid-EMIT after 4 beats: all outputs go to 0 immediately.
   - A new `start` runs a full clean sample, and the batch counter restarts from 0.
6. Protocol violations: `start` while `busy`, and `fc_valid` in IDLE → both are ignored and state is unchanged.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared Q8.8 fixed-point constants, saturating arithmetic and the error-stage state encoding.
package cnn_pkg;

  localparam int Q_WIDTH = 16;
  localparam int FRAC_BITS = 8;
  localparam logic [Q_WIDTH-1:0] FIXED_ONE = 16'h0100;
  localparam int LOSS_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_EMIT,
    S_DONE
  } state_e;

  // Difference is formed one bit wider so overflow shows up as a sign-bit disagreement.
  function automatic logic [Q_WIDTH-1:0] sat_sub(input logic [Q_WIDTH-1:0] a,
                                                 input logic [Q_WIDTH-1:0] b);
    logic [Q_WIDTH:0] d;
    d = {a[Q_WIDTH-1], a} - {b[Q_WIDTH-1], b};
    if (d[Q_WIDTH] != d[Q_WIDTH-1]) begin
      return d[Q_WIDTH] ? {1'b1, {(Q_WIDTH-1){1'b0}}} : {1'b0, {(Q_WIDTH-1){1'b1}}};
    end
    return d[Q_WIDTH-1:0];
  endfunction

  // Most negative value has no positive twin; it clips to the largest positive value.
  function automatic logic [Q_WIDTH-1:0] abs_sat(input logic [Q_WIDTH-1:0] a);
    if (a[Q_WIDTH-1]) begin
      if (a == {1'b1, {(Q_WIDTH-1){1'b0}}}) begin
        return {1'b0, {(Q_WIDTH-1){1'b1}}};
      end
      return -a;
    end
    return a;
  endfunction

  function automatic logic [LOSS_W-1:0] sat_add_u(input logic [LOSS_W-1:0] a,
                                                  input logic [LOSS_W-1:0] b);
    logic [LOSS_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[LOSS_W] ? {LOSS_W{1'b1}} : s[LOSS_W-1:0];
  endfunction

endpackage

// File: rtl/output_error_unit_if.sv
// Sample input stream, error output stream and per-sample / per-batch status of the error stage.
interface output_error_unit_if #(
  parameter int OUTPUT_SIZE = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int BATCH_SIZE  = 32,
  parameter int LOSS_WIDTH  = 32
);
  localparam int IW = $clog2(OUTPUT_SIZE);
  localparam int CW = $clog2(BATCH_SIZE + 1);

  logic                  start;
  logic [IW-1:0]         label;
  logic [DATA_WIDTH-1:0] fc_data;
  logic                  fc_valid;
  logic [DATA_WIDTH-1:0] err_data;
  logic [IW-1:0]         err_index;
  logic                  err_valid;
  logic                  err_ready;
  logic                  busy;
  logic                  sample_done;
  logic                  correct;
  logic                  batch_done;
  logic [LOSS_WIDTH-1:0] batch_loss;
  logic [CW-1:0]         batch_correct;

  modport slave (
    input  start, label, fc_data, fc_valid, err_ready,
    output err_data, err_index, err_valid, busy, sample_done, correct,
           batch_done, batch_loss, batch_correct
  );

  modport master (
    output start, label, fc_data, fc_valid, err_ready,
    input  err_data, err_index, err_valid, busy, sample_done, correct,
           batch_done, batch_loss, batch_correct
  );
endinterface

// File: rtl/argmax_tracker.sv
// Streaming argmax over one sample; strict greater-than keeps the lowest index on ties.
// Latency: max_idx reflects a value one cycle after its in_vld.
// Backpressure: none, accepts a value every cycle.
module argmax_tracker #(
  parameter int DATA_WIDTH = 16,
  parameter int IW         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         in_vld,
  input  logic signed [DATA_WIDTH-1:0] in_dat,
  input  logic [IW-1:0]                in_idx,
  output logic [IW-1:0]                max_idx
);
  logic                         first_q, first_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic [IW-1:0]                idx_q, idx_d;

  always_comb begin
    first_d = first_q;
    max_d   = max_q;
    idx_d   = idx_q;
    if (clr) begin
      first_d = 1'b1;
    end else if (in_vld) begin
      first_d = 1'b0;
      if (first_q || (in_dat > max_q)) begin
        max_d = in_dat;
        idx_d = in_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_q <= 1'b1;
      max_q   <= '0;
      idx_q   <= '0;
    end else begin
      first_q <= first_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
    end
  end

  assign max_idx = idx_q;

endmodule

// File: rtl/output_error_unit.sv
// Per-class output error (fc - one_hot(label)) with per-sample correctness and per-batch loss/accuracy.
// Latency: first error beat the cycle after the last fc value; sample_done one cycle after the last accepted beat.
// Backpressure: err stream holds data/index while err_valid && !err_ready; fc input has none.
module output_error_unit #(
  parameter int OUTPUT_SIZE = 10,
  parameter int DATA_WIDTH  = cnn_pkg::Q_WIDTH,
  parameter int FRAC_BITS   = cnn_pkg::FRAC_BITS,
  parameter int BATCH_SIZE  = 32,
  parameter int LOSS_WIDTH  = cnn_pkg::LOSS_W
) (
  input  logic               clk,
  input  logic               reset,
  output_error_unit_if.slave io
);
  import cnn_pkg::*;

  localparam int IW = $clog2(OUTPUT_SIZE);
  localparam int CW = $clog2(BATCH_SIZE + 1);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << FRAC_BITS;

  state_e                       state_q, state_d;
  logic [IW-1:0]                label_q, label_d;
  logic [IW-1:0]                cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] vals_q [OUTPUT_SIZE];
  logic signed [DATA_WIDTH-1:0] vals_d [OUTPUT_SIZE];
  logic [LOSS_WIDTH-1:0]        samp_loss_q, samp_loss_d;
  logic [LOSS_WIDTH-1:0]        acc_loss_q, acc_loss_d;
  logic [LOSS_WIDTH-1:0]        batch_loss_q, batch_loss_d;
  logic [CW-1:0]                acc_corr_q, acc_corr_d;
  logic [CW-1:0]                samp_cnt_q, samp_cnt_d;
  logic [CW-1:0]                batch_corr_q, batch_corr_d;
  logic                         correct_q, correct_d;
  logic                         batch_done_q, batch_done_d;

  logic                  start_acc, fc_acc, beat_acc, last_beat;
  logic                  label_ok, correct_now;
  logic [IW-1:0]         max_idx;
  logic [DATA_WIDTH-1:0] err_dat;
  logic [LOSS_WIDTH-1:0] samp_total, new_loss;
  logic [CW-1:0]         new_corr, new_cnt;

  assign start_acc   = (state_q == S_IDLE) && io.start;
  assign fc_acc      = (state_q == S_COLLECT) && io.fc_valid;
  assign beat_acc    = (state_q == S_EMIT) && io.err_ready;
  assign last_beat   = beat_acc && (cnt_q == IW'(OUTPUT_SIZE - 1));
  // Out-of-range labels subtract nothing and can never be correct.
  assign label_ok    = int'(label_q) < OUTPUT_SIZE;
  assign correct_now = label_ok && (max_idx == label_q);
  assign err_dat     = sat_sub(vals_q[cnt_q],
                               (label_ok && (cnt_q == label_q)) ? ONE : '0);
  assign samp_total  = samp_loss_q + LOSS_WIDTH'(abs_sat(err_dat));
  assign new_loss    = sat_add_u(acc_loss_q, samp_total);
  assign new_corr    = acc_corr_q + CW'(correct_now);
  assign new_cnt     = samp_cnt_q + CW'(1);

  argmax_tracker #(
    .DATA_WIDTH(DATA_WIDTH),
    .IW        (IW)
  ) u_argmax (
    .clk    (clk),
    .reset  (reset),
    .clr    (start_acc),
    .in_vld (fc_acc),
    .in_dat (io.fc_data),
    .in_idx (cnt_q),
    .max_idx(max_idx)
  );

  // Sample/batch bookkeeping is committed on the final accepted beat so that
  // correct, batch_loss and batch_correct are already valid in the DONE cycle.
  always_comb begin
    state_d      = state_q;
    label_d      = label_q;
    cnt_d        = cnt_q;
    vals_d       = vals_q;
    samp_loss_d  = samp_loss_q;
    acc_loss_d   = acc_loss_q;
    batch_loss_d = batch_loss_q;
    acc_corr_d   = acc_corr_q;
    samp_cnt_d   = samp_cnt_q;
    batch_corr_d = batch_corr_q;
    correct_d    = correct_q;
    batch_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          label_d     = io.label;
          cnt_d       = '0;
          samp_loss_d = '0;
          state_d     = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (fc_acc) begin
          vals_d[cnt_q] = io.fc_data;
          if (cnt_q == IW'(OUTPUT_SIZE - 1)) begin
            cnt_d   = '0;
            state_d = S_EMIT;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      S_EMIT: begin
        if (beat_acc) begin
          samp_loss_d = samp_total;
          cnt_d       = cnt_q + IW'(1);
        end
        if (last_beat) begin
          cnt_d      = '0;
          state_d    = S_DONE;
          correct_d  = correct_now;
          acc_loss_d = new_loss;
          acc_corr_d = new_corr;
          samp_cnt_d = new_cnt;
          if (new_cnt == CW'(BATCH_SIZE)) begin
            batch_loss_d = new_loss;
            batch_corr_d = new_corr;
            acc_loss_d   = '0;
            acc_corr_d   = '0;
            samp_cnt_d   = '0;
            batch_done_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      label_q      <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < OUTPUT_SIZE; i++) vals_q[i] <= '0;
      samp_loss_q  <= '0;
      acc_loss_q   <= '0;
      batch_loss_q <= '0;
      acc_corr_q   <= '0;
      samp_cnt_q   <= '0;
      batch_corr_q <= '0;
      correct_q    <= 1'b0;
      batch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      label_q      <= label_d;
      cnt_q        <= cnt_d;
      vals_q       <= vals_d;
      samp_loss_q  <= samp_loss_d;
      acc_loss_q   <= acc_loss_d;
      batch_loss_q <= batch_loss_d;
      acc_corr_q   <= acc_corr_d;
      samp_cnt_q   <= samp_cnt_d;
      batch_corr_q <= batch_corr_d;
      correct_q    <= correct_d;
      batch_done_q <= batch_done_d;
    end
  end

  assign io.err_valid     = (state_q == S_EMIT);
  assign io.err_data      = io.err_valid ? err_dat : '0;
  assign io.err_index     = io.err_valid ? cnt_q : '0;
  assign io.busy          = (state_q != S_IDLE);
  assign io.sample_done   = (state_q == S_DONE);
  assign io.correct       = correct_q;
  assign io.batch_done    = batch_done_q;
  assign io.batch_loss    = batch_loss_q;
  assign io.batch_correct = batch_corr_q;

endmodule
